instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 17 +
 rtl/instr_fetch_if.sv | 28 ++
 rtl/instr_fetch_target_lut.sv | 28 ++
 rtl/instr_fetch.sv | 93 +++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding and widths.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam int unsigned PC_W      = 10;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned LUT_DEPTH = 32;
  localparam int unsigned OFF_W     = 8;
  localparam int unsigned INSTR_W   = 9;
  localparam int unsigned CNT_W     = 16;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: control inputs from testbench/ROM/decoder/ALU, PC and status back.
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic               Start;
  logic [PC_W-1:0]    StartAddr;
  logic [INSTR_W-1:0] Instruction;
  logic               Ack;
  logic               GotoEn;
  logic               BranchEn;
  logic               Jump2En;
  logic               Zero;
  logic [PC_W-1:0]    PC;
  logic               InstrValid;
  logic               Done;
  logic [CNT_W-1:0]   CycleCount;

  modport master (
    output Start, StartAddr, Instruction, Ack, GotoEn, BranchEn, Jump2En, Zero,
    input  PC, InstrValid, Done, CycleCount
  );

  modport slave (
    input  Start, StartAddr, Instruction, Ack, GotoEn, BranchEn, Jump2En, Zero,
    output PC, InstrValid, Done, CycleCount
  );

endinterface

// File: rtl/instr_fetch_target_lut.sv
// target_lut: constant jump-target and branch-offset tables, purely combinational.
module target_lut
  import instr_fetch_pkg::*;
(
  input  logic        [IDX_W-1:0] idx_i,
  output logic        [PC_W-1:0]  target_o,
  output logic signed [OFF_W-1:0] offset_o
);

  // Targets are idx*40+80 modulo 1024; offsets are idx-16.
  localparam logic [PC_W-1:0] TARGET_LUT [LUT_DEPTH] = '{
    10'd80,  10'd120, 10'd160, 10'd200, 10'd240, 10'd280, 10'd320, 10'd360,
    10'd400, 10'd440, 10'd480, 10'd520, 10'd560, 10'd600, 10'd640, 10'd680,
    10'd720, 10'd760, 10'd800, 10'd840, 10'd880, 10'd920, 10'd960, 10'd1000,
    10'd16,  10'd56,  10'd96,  10'd136, 10'd176, 10'd216, 10'd256, 10'd296
  };

  localparam logic signed [OFF_W-1:0] OFFSET_LUT [LUT_DEPTH] = '{
    -8'sd16, -8'sd15, -8'sd14, -8'sd13, -8'sd12, -8'sd11, -8'sd10, -8'sd9,
    -8'sd8,  -8'sd7,  -8'sd6,  -8'sd5,  -8'sd4,  -8'sd3,  -8'sd2,  -8'sd1,
     8'sd0,   8'sd1,   8'sd2,   8'sd3,   8'sd4,   8'sd5,   8'sd6,   8'sd7,
     8'sd8,   8'sd9,   8'sd10,  8'sd11,  8'sd12,  8'sd13,  8'sd14,  8'sd15
  };

  assign target_o = TARGET_LUT[idx_i];
  assign offset_o = OFFSET_LUT[idx_i];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch FSM (IDLE/RUN/HALT) driving the ROM program counter.
// Optional cycle counter selected by macro FETCH_CYCLE_COUNT_EN.
module instr_fetch
  import instr_fetch_pkg::*;
(
  input  logic         Clk,
  input  logic         Reset,
  instr_fetch_if.slave bus
);

  fetch_state_e       state_q;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    pc_d;
  logic               valid_q;
  logic               done_q;
  logic [PC_W-1:0]    target;
  logic signed [OFF_W-1:0] offset;
  logic               unused_instr;

  assign unused_instr = ^bus.Instruction[INSTR_W-1:IDX_W];

  target_lut u_target_lut (
    .idx_i    (bus.Instruction[IDX_W-1:0]),
    .target_o (target),
    .offset_o (offset)
  );

  // Non-Ack RUN successor; Ack is resolved in the FSM since it also changes state.
  always_comb begin
    pc_d = pc_q + PC_W'(1);
    if (bus.GotoEn)
      pc_d = target;
    else if (bus.BranchEn && bus.Zero)
      pc_d = pc_q + {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};
    else if (bus.Jump2En && bus.Zero)
      pc_d = pc_q + PC_W'(2);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.Start) begin
          state_q <= RUN;
          pc_q    <= bus.StartAddr;
          valid_q <= 1'b1;
        end
        RUN: if (bus.Ack) begin
          state_q <= HALT;
          valid_q <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          pc_q <= pc_d;
        end
        HALT: if (!bus.Start) begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PC         = pc_q;
  assign bus.InstrValid = valid_q;
  assign bus.Done       = done_q;

`ifdef FETCH_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      cnt_q <= '0;
    else if (state_q == IDLE && bus.Start)
      cnt_q <= '0;
    else if (state_q == RUN && cnt_q != '1)
      cnt_q <= cnt_q + CNT_W'(1);
  end

  assign bus.CycleCount = cnt_q;
`else
  assign bus.CycleCount = '0;
`endif

endmodule
